// File: rtl/int_sequencer_pkg.sv
// int_sequencer_pkg: shared FSM encodings, Q4 phase and default interrupt vector.
package int_sequencer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;
  localparam logic [12:0] INT_VECTOR_DEF = 13'h0004;
endpackage

// File: rtl/int_sequencer_return_stack.sv
// return_stack: circular return-address stack; pop wins over a simultaneous push.
// INT_STACK_DIAG_EN adds an occupancy counter driving sticky ovf/unf flags.
module return_stack #(
  parameter int W = 13,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH)-1:0] sp,
  output logic                     ovf,
  output logic                     unf
);
  localparam int SPW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  assign dout = r_mem[r_sp - SPW'(1)];
  assign sp = r_sp;
  always_ff @(posedge clk)
    if (rst) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (pop) r_sp <= r_sp - SPW'(1);
    else if (push) begin
      r_mem[r_sp] <= din;
      r_sp <= r_sp + SPW'(1);
    end
`ifdef INT_STACK_DIAG_EN
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] r_cnt;
  logic r_ovf, r_unf;
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (pop) begin
      if (r_cnt == '0) r_unf <= 1'b1;
      else r_cnt <= r_cnt - CW'(1);
      if (push) r_ovf <= 1'b1;
    end else if (push) begin
      if (r_cnt == CW'(DEPTH)) r_ovf <= 1'b1;
      else r_cnt <= r_cnt + CW'(1);
    end
  assign ovf = r_ovf;
  assign unf = r_unf;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: interrupt dispatch at Q4, GIE ownership and return-stack control.
// Define INT_STACK_DIAG_EN to build stack overflow/underflow diagnostics.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 13,
  parameter int STACK_DEPTH = 8,
  parameter int N_SRC = 4,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR = PC_WIDTH'(INT_VECTOR_DEF)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     q_count,
  input  logic                           accept_ok,
  input  logic [PC_WIDTH-1:0]            pc_in,
  input  logic                           call_req,
  input  logic                           ret_req,
  input  logic                           retfie,
  input  logic                           gie_wr_en,
  input  logic                           gie_wr_data,
  input  logic [N_SRC-1:0]               int_flags,
  input  logic [N_SRC-1:0]               int_enables,
  output logic                           gie,
  output logic                           pc_load_en,
  output logic [PC_WIDTH-1:0]            pc_load_val,
  output logic                           instr_flush_int,
  output logic                           int_taken,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr,
  output logic                           stack_ovf,
  output logic                           stack_unf
);
  logic w_q4, w_cond, w_dispatch, w_push, w_pop;
  logic [1:0] r_state, w_next;
  logic r_gie;
  logic [PC_WIDTH-1:0] w_top;
  // A cycle under reset never counts as Q4, so no pulse or stack action leaks out.
  assign w_q4 = (q_count == Q4) & ~rst;
  assign w_cond = r_gie & |(int_flags & int_enables);
  assign w_dispatch = w_q4 & w_cond & accept_ok & ~call_req & ~ret_req & (r_state != ST_FLUSH);
  assign w_pop = w_q4 & ret_req;
  assign w_push = (w_q4 & call_req) | w_dispatch;
  assign w_next = (r_state == ST_FLUSH) ? (w_q4 ? ST_IDLE : ST_FLUSH) :
                  w_dispatch ? ST_FLUSH : w_cond ? ST_PENDING : ST_IDLE;
  assign pc_load_en = w_dispatch | w_pop;
  assign pc_load_val = w_dispatch ? INT_VECTOR : w_top;
  assign instr_flush_int = w_dispatch | w_pop;
  assign int_taken = w_dispatch;
  assign gie = r_gie;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_gie <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gie <= w_dispatch ? 1'b0 : (w_pop & retfie) ? 1'b1 : gie_wr_en ? gie_wr_data : r_gie;
    end
  return_stack #(.W(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .din(pc_in),
    .dout(w_top),
    .sp(stack_ptr),
    .ovf(stack_ovf),
    .unf(stack_unf)
  );
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed per-scenario checks of dispatch, GIE and the return stack.
module tb_int_sequencer;
  logic clk = 0, rst = 0;
  logic [1:0] q_count = 0;
  logic accept_ok = 0, call_req = 0, ret_req = 0, retfie = 0, gie_wr_en = 0, gie_wr_data = 0;
  logic [12:0] pc_in = 0;
  logic [3:0] int_flags = 0, int_enables = 4'b0010;
  logic gie, pc_load_en, instr_flush_int, int_taken, stack_ovf, stack_unf;
  logic [12:0] pc_load_val;
  logic [2:0] stack_ptr;
  logic s_en, s_flush, s_taken, s_early;
  logic [12:0] s_val;
  int errors = 0, checks = 0;
`ifdef INT_STACK_DIAG_EN
  localparam logic DIAG = 1'b1;
`else
  localparam logic DIAG = 1'b0;
`endif

  int_sequencer dut (
    .clk(clk), .rst(rst), .q_count(q_count), .accept_ok(accept_ok), .pc_in(pc_in),
    .call_req(call_req), .ret_req(ret_req), .retfie(retfie), .gie_wr_en(gie_wr_en),
    .gie_wr_data(gie_wr_data), .int_flags(int_flags), .int_enables(int_enables),
    .gie(gie), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
    .instr_flush_int(instr_flush_int), .int_taken(int_taken), .stack_ptr(stack_ptr),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  // One instruction: Q1..Q4, flags change at Q3, optional GIE write at Q4; Q4 outputs captured.
  task automatic instr(input logic a, input logic [12:0] pc, input logic c, input logic r,
                       input logic rf, input logic gw, input logic [3:0] fl);
    s_early = 0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      q_count = 2'(p);
      accept_ok = a;
      pc_in = pc;
      call_req = c;
      ret_req = r;
      retfie = rf;
      if (p == 2) int_flags = fl;
      gie_wr_en = (p == 3) & gw;
      gie_wr_data = 1;
      #1;
      if (p < 3) s_early = s_early | pc_load_en | int_taken | instr_flush_int;
      else begin
        s_en = pc_load_en;
        s_val = pc_load_val;
        s_flush = instr_flush_int;
        s_taken = int_taken;
      end
    end
    @(negedge clk);
    q_count = 0;
    call_req = 0;
    ret_req = 0;
    retfie = 0;
    gie_wr_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    q_count = 0; call_req = 0; ret_req = 0; retfie = 0; gie_wr_en = 0; int_flags = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic set_gie(input logic v);
    @(negedge clk);
    q_count = 0;
    gie_wr_en = 1;
    gie_wr_data = v;
    @(negedge clk);
    gie_wr_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (gie !== 1'b0) begin errors++; $display("FAIL reset_gie got %b want 0", gie); end
    checks++; if (stack_ptr !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", stack_ptr); end
    checks++; if ({pc_load_en, int_taken, instr_flush_int} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {pc_load_en, int_taken, instr_flush_int}); end
    checks++; if ({stack_ovf, stack_unf} !== 2'b00) begin errors++; $display("FAIL reset_diag got %b want 00", {stack_ovf, stack_unf}); end
  endtask

  task automatic test_dispatch();
    set_gie(1);
    checks++; if (gie !== 1'b1) begin errors++; $display("FAIL sw_gie got %b want 1", gie); end
    instr(1, 13'h010, 0, 0, 0, 0, 4'b0010);
    checks++; if ({s_taken, s_en, s_flush} !== 3'b111) begin errors++; $display("FAIL disp_pulses got %b want 111", {s_taken, s_en, s_flush}); end
    checks++; if (s_val !== 13'h004) begin errors++; $display("FAIL disp_vector got %h want 004", s_val); end
    checks++; if (s_early !== 1'b0) begin errors++; $display("FAIL disp_not_q4 got %b want 0", s_early); end
    checks++; if ({gie, stack_ptr} !== {1'b0, 3'd1}) begin errors++; $display("FAIL disp_state gie/sp got %b/%0d want 0/1", gie, stack_ptr); end
    instr(0, 13'h011, 0, 0, 0, 0, 4'b0010);
    checks++; if (s_taken !== 1'b0) begin errors++; $display("FAIL flush_slot_taken got %b want 0", s_taken); end
    instr(1, 13'h005, 0, 1, 0, 0, 4'b0000);
    checks++; if ({s_en, s_val} !== {1'b1, 13'h010}) begin errors++; $display("FAIL disp_ret got %b/%h want 1/010", s_en, s_val); end
    checks++; if (stack_ptr !== 3'd0) begin errors++; $display("FAIL disp_ret_sp got %0d want 0", stack_ptr); end
  endtask

  task automatic test_call_defer();
    set_gie(1);
    int_flags = 4'b0010;
    instr(1, 13'h123, 1, 0, 0, 0, 4'b0010);
    checks++; if ({s_taken, s_en} !== 2'b00) begin errors++; $display("FAIL defer_call got %b want 00", {s_taken, s_en}); end
    checks++; if ({gie, stack_ptr} !== {1'b1, 3'd1}) begin errors++; $display("FAIL defer_state gie/sp got %b/%0d want 1/1", gie, stack_ptr); end
    instr(1, 13'h200, 0, 0, 0, 0, 4'b0010);
    checks++; if ({s_taken, s_val} !== {1'b1, 13'h004}) begin errors++; $display("FAIL defer_dispatch got %b/%h want 1/004", s_taken, s_val); end
    checks++; if ({gie, stack_ptr} !== {1'b0, 3'd2}) begin errors++; $display("FAIL defer_sp gie/sp got %b/%0d want 0/2", gie, stack_ptr); end
    instr(0, 13'h201, 0, 0, 0, 0, 4'b0000);
  endtask

  task automatic test_retfie();
    instr(1, 13'h456, 1, 0, 0, 0, 4'b0000);
    checks++; if (stack_ptr !== 3'd3) begin errors++; $display("FAIL retfie_push_sp got %0d want 3", stack_ptr); end
    instr(1, 13'h300, 0, 1, 1, 0, 4'b0010);
    checks++; if ({s_en, s_flush, s_taken, s_val} !== {3'b110, 13'h456}) begin errors++; $display("FAIL retfie_load got %b%b%b/%h want 110/456", s_en, s_flush, s_taken, s_val); end
    checks++; if ({gie, stack_ptr} !== {1'b1, 3'd2}) begin errors++; $display("FAIL retfie_state gie/sp got %b/%0d want 1/2", gie, stack_ptr); end
    instr(0, 13'h457, 0, 0, 0, 0, 4'b0010);
    checks++; if (s_taken !== 1'b0) begin errors++; $display("FAIL retfie_flushed got %b want 0", s_taken); end
    instr(1, 13'h457, 0, 0, 0, 0, 4'b0010);
    checks++; if ({s_taken, gie, stack_ptr} !== {2'b10, 3'd3}) begin errors++; $display("FAIL retfie_redispatch taken/gie/sp got %b/%b/%0d want 1/0/3", s_taken, gie, stack_ptr); end
    instr(0, 13'h458, 0, 0, 0, 0, 4'b0000);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      instr(1, 13'(i), 1, 0, 0, 0, 4'b0000);
      if (i == 8) begin
        checks++; if (stack_ptr !== 3'd0) begin errors++; $display("FAIL wrap_sp8 got %0d want 0", stack_ptr); end
      end
    end
    checks++; if (stack_ptr !== 3'd1) begin errors++; $display("FAIL wrap_sp9 got %0d want 1", stack_ptr); end
    instr(1, 13'h00A, 0, 1, 0, 0, 4'b0000);
    checks++; if (s_val !== 13'h009) begin errors++; $display("FAIL wrap_ret got %h want 009", s_val); end
    checks++; if (stack_ptr !== 3'd0) begin errors++; $display("FAIL wrap_ret_sp got %0d want 0", stack_ptr); end
    checks++; if ({stack_ovf, stack_unf} !== {DIAG, 1'b0}) begin errors++; $display("FAIL wrap_diag got %b want %b0", {stack_ovf, stack_unf}, DIAG); end
  endtask

  task automatic test_underflow();
    do_reset();
    instr(1, 13'h020, 0, 1, 0, 0, 4'b0000);
    checks++; if ({s_en, s_val} !== {1'b1, 13'h000}) begin errors++; $display("FAIL unf_ret got %b/%h want 1/000", s_en, s_val); end
    checks++; if (stack_ptr !== 3'd7) begin errors++; $display("FAIL unf_sp got %0d want 7", stack_ptr); end
    checks++; if ({stack_ovf, stack_unf} !== {1'b0, DIAG}) begin errors++; $display("FAIL unf_diag got %b want 0%b", {stack_ovf, stack_unf}, DIAG); end
  endtask

  task automatic test_call_ret();
    do_reset();
    instr(1, 13'h0AA, 1, 0, 0, 0, 4'b0000);
    instr(1, 13'h0BB, 1, 1, 0, 0, 4'b0000);
    checks++; if (s_val !== 13'h0AA) begin errors++; $display("FAIL callret_val got %h want 0aa", s_val); end
    checks++; if (stack_ptr !== 3'd0) begin errors++; $display("FAIL callret_sp got %0d want 0", stack_ptr); end
    checks++; if (stack_ovf !== DIAG) begin errors++; $display("FAIL callret_ovf got %b want %b", stack_ovf, DIAG); end
  endtask

  task automatic test_gie_write_dispatch();
    do_reset();
    set_gie(1);
    int_flags = 4'b0010;
    instr(1, 13'h040, 0, 0, 0, 1, 4'b0010);
    checks++; if (s_taken !== 1'b1) begin errors++; $display("FAIL gwd_taken got %b want 1", s_taken); end
    checks++; if (gie !== 1'b0) begin errors++; $display("FAIL gwd_gie got %b want 0", gie); end
    instr(1, 13'h041, 0, 0, 0, 0, 4'b0010);
    checks++; if (s_taken !== 1'b0) begin errors++; $display("FAIL gwd_no_redispatch got %b want 0", s_taken); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    set_gie(1);
    int_flags = 4'b0010;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      q_count = 2'(p);
      accept_ok = 1;
    end
    @(negedge clk);
    q_count = 3;
    rst = 1;
    #1;
    checks++; if ({int_taken, pc_load_en} !== 2'b00) begin errors++; $display("FAIL rstp_pulse got %b want 00", {int_taken, pc_load_en}); end
    @(negedge clk);
    rst = 0;
    q_count = 0;
    checks++; if ({gie, stack_ptr} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rstp_state gie/sp got %b/%0d want 0/0", gie, stack_ptr); end
    instr(1, 13'h050, 0, 0, 0, 0, 4'b0010);
    checks++; if (s_taken !== 1'b0) begin errors++; $display("FAIL rstp_no_dispatch got %b want 0", s_taken); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_call_defer();
    test_retfie();
    test_wrap();
    test_underflow();
    test_call_ret();
    test_gie_write_dispatch();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
